axi4_bram_responder: RTL
========================

// Module: axi4_bram_responder
// PURPOSE
//  AXI4 slave (responder) backed by on-chip dual-port BRAM. It answers the AXI4 master side of
//  noc_axi4_bridge in place of the MIG DDR3 controller. Used for DDR-less chipset bring-up and as
//  a deterministic memory model in simulation. Read and write channels are independent FSMs.
// PARAMETERS
//  ADDR_WIDTH  64   AXI address width
//  DATA_WIDTH  512  AXI data width; power of 2, >=32
//  ID_WIDTH    16   AXI ID width
//  MEM_AW      10   log2(memory depth in DATA_WIDTH words)
// PORTS
//  clk      in  1            clock; all logic on rising edge
//  rst_n    in  1            reset; asynchronous, active-low
//  awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address channel
//  awvalid in 1; awready out 1   AW handshake
//  wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1
//  bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1
//  arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address channel
//  arvalid in 1; arready out 1   AR handshake
//  rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1
// BEHAVIOUR
//  Reset: all outputs 0; FSMs -> IDLE; memory contents not reset. Async assert/clear.
//  awready/arready are flops. They rise on the first clk edge after rst_n deasserts.
//  Word index = addr[OFF+MEM_AW-1:OFF], where OFF = log2(DATA_WIDTH/8). Low OFF bits are ignored.
//  AxSIZE is not a port. Every beat is one full word; wstrb selects which bytes are written.
//  Decode at address accept: addr[ADDR_WIDTH-1:OFF+MEM_AW] != 0 -> DECERR (2'b11).
//  Else burst WRAP(2'b10) or 2'b11 -> SLVERR (2'b10). Else OKAY (2'b00).
//  FIXED: index held for all beats. INCR: index +1 per beat, modulo 2^MEM_AW; a boundary wrap is legal.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1. On awvalid&awready, latch id/index/len/burst/err and go to W_DATA.
//   W_DATA: wready=1. Each wvalid beat writes the memory only if err==OKAY.
//    The beat counter counts to awlen+1.
//    wlast on a beat other than the last, or missing on the last, forces bresp=SLVERR if it was OKAY.
//   The last beat (count = awlen) goes to W_RESP regardless of wlast.
//   W_RESP: bvalid=1, bid=latched id, bresp held stable until bready. Then W_IDLE; awready=1 next cycle.
//  Read FSM R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE):
//   R_IDLE: arready=1. On handshake, latch id/index/len/burst/err and go to R_FETCH.
//   R_FETCH: sync BRAM read of index (1-cycle latency). Next state R_DATA.
//   R_DATA: rvalid=1; rdata/rid/rresp/rlast held stable until rready.
//    rlast=1 on beat arlen. rdata=0 when err!=OKAY.
//    On handshake: last beat -> R_IDLE; else advance index and go to R_FETCH.
//   Timing: first rvalid 2 cycles after the AR handshake. rvalid is low exactly 1 cycle between beats.
//  Only one outstanding transaction per direction. A new AW/AR is accepted only in IDLE.
//  Same-cycle read and write to the same word: the read returns old data (read-first).
//  Write with wstrb=0: the beat completes with no byte changed.
//  Mid-burst reset: the burst is abandoned; bytes already written stay written.
//  No output goes X after reset release.
// TESTING
//  1. Reset, then AW addr=0x40 len=3 INCR, 4 beats all-strobe.
//     -> bresp=OKAY, bid matches. AR same address -> 4 beats, words 1..4 in order;
//     rlast only on beat 4; first rvalid at +2 cycles.
//  2. INCR write at word 2^MEM_AW-1, len=1 -> the second beat lands in word 0.
//     Readback confirms both words.
//  3. awaddr bit OFF+MEM_AW set -> bresp=DECERR, memory unchanged.
//     Read of the same address -> rdata=0, rresp=DECERR on every beat.
//  4. WRAP burst -> SLVERR with no write. Write len=2 with wlast on beat 1
//     -> 3 beats accepted, bresp=SLVERR.
//  5. Random bready/rready backpressure, with concurrent read and write to one word
//     -> outputs stable while stalled; read-first data observed.
//  6. Assert rst_n low mid-read and mid-write -> all outputs 0 immediately.
//     awready/arready =1 one cycle after release.

Source files
------------

// File: rtl/axi4_bram_responder.sv
// AXI4 slave backed by on-chip BRAM, standing in for the DDR3 controller behind noc_axi4_bridge.
// Independent read and write FSMs, one burst in flight per direction.
module axi4_bram_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 16,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    wstate_t             w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [MEM_AW-1:0]   w_idx_q, w_idx_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [7:0]          w_cnt_q, w_cnt_d;
    logic                w_incr_q, w_incr_d;
    logic                w_wen_q, w_wen_d;
    logic [1:0]          w_resp_q, w_resp_d;
    logic                awready_q, awready_d;
    logic                mem_we;

    rstate_t             r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [MEM_AW-1:0]   r_idx_q, r_idx_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [7:0]          r_cnt_q, r_cnt_d;
    logic                r_incr_q, r_incr_d;
    logic [1:0]          r_resp_q, r_resp_d;
    logic                arready_q, arready_d;

    logic [1:0]          aw_err, ar_err;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^{awaddr_i[OFF-1:0], araddr_i[OFF-1:0]};

    // Address decode happens once, at accept; out-of-range beats the burst-type check.
    always_comb begin
        aw_err = RESP_OKAY;
        if (awaddr_i[ADDR_WIDTH-1:OFF+MEM_AW] != '0) aw_err = RESP_DECERR;
        else if (awburst_i[1])                       aw_err = RESP_SLVERR;
        ar_err = RESP_OKAY;
        if (araddr_i[ADDR_WIDTH-1:OFF+MEM_AW] != '0) ar_err = RESP_DECERR;
        else if (arburst_i[1])                       ar_err = RESP_SLVERR;
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_incr_d  = w_incr_q;
        w_wen_d   = w_wen_q;
        w_resp_d  = w_resp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_i && awready_q) begin
                    w_id_d    = awid_i;
                    w_idx_d   = awaddr_i[OFF+MEM_AW-1:OFF];
                    w_len_d   = awlen_i;
                    w_cnt_d   = 8'd0;
                    w_incr_d  = (awburst_i == BURST_INCR);
                    w_wen_d   = (aw_err == RESP_OKAY);
                    w_resp_d  = aw_err;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid_i) begin
                    mem_we = w_wen_q;
                    // A misplaced or missing wlast only downgrades an otherwise clean burst.
                    if ((wlast_i != (w_cnt_q == w_len_q)) && (w_resp_q == RESP_OKAY))
                        w_resp_d = RESP_SLVERR;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (w_incr_q) w_idx_d = w_idx_q + MEM_AW'(1);
                    end
                end
            end
            W_RESP: begin
                if (bready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_incr_d  = r_incr_q;
        r_resp_d  = r_resp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_i && arready_q) begin
                    r_id_d    = arid_i;
                    r_idx_d   = araddr_i[OFF+MEM_AW-1:OFF];
                    r_len_d   = arlen_i;
                    r_cnt_d   = 8'd0;
                    r_incr_d  = (arburst_i == BURST_INCR);
                    r_resp_d  = ar_err;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                if (rready_i) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        if (r_incr_q) r_idx_d = r_idx_q + MEM_AW'(1);
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_incr_q  <= 1'b0;
            w_wen_q   <= 1'b0;
            w_resp_q  <= RESP_OKAY;
            awready_q <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_incr_q  <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            arready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_incr_q  <= w_incr_d;
            w_wen_q   <= w_wen_d;
            w_resp_q  <= w_resp_d;
            awready_q <= awready_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_incr_q  <= r_incr_d;
            r_resp_q  <= r_resp_d;
            arready_q <= arready_d;
        end
    end

    // BRAM is never reset; a same-edge read of the word being written sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) mem[w_idx_q][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (r_state_q == R_FETCH) rdata_q <= mem[r_idx_q];
    end

    assign awready_o = awready_q;
    assign wready_o  = (w_state_q == W_DATA);
    assign bvalid_o  = (w_state_q == W_RESP);
    assign bid_o     = bvalid_o ? w_id_q : '0;
    assign bresp_o   = bvalid_o ? w_resp_q : RESP_OKAY;

    assign arready_o = arready_q;
    assign rvalid_o  = (r_state_q == R_DATA);
    assign rid_o     = rvalid_o ? r_id_q : '0;
    assign rresp_o   = rvalid_o ? r_resp_q : RESP_OKAY;
    assign rlast_o   = rvalid_o && (r_cnt_q == r_len_q);
    assign rdata_o   = (rvalid_o && (r_resp_q == RESP_OKAY)) ? rdata_q : '0;

endmodule
